// File: rtl/fetch_pkg.sv
// Shared redirect-type encodings, default exception vector and queue entry type for the fetch stage.
package fetch_pkg;

    localparam logic [1:0] SEL_BRANCH = 2'b00;
    localparam logic [1:0] SEL_REG    = 2'b01;
    localparam logic [1:0] SEL_INDEX  = 2'b10;
    localparam logic [1:0] SEL_EXC    = 2'b11;

    localparam int unsigned FETCH_ADDR_W  = 32;
    localparam int unsigned FETCH_INSTR_W = 32;

    localparam logic [FETCH_ADDR_W-1:0] DEFAULT_EXC_VECTOR = 32'h0000_0040;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  nextpc;
        logic [FETCH_INSTR_W-1:0] instruc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; push and pop may coincide at any fill level, including full.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            push,
    input  entry_t          wdata,
    input  logic            pop,
    output entry_t          rdata,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    // A pop frees the slot this cycle, so a full queue still accepts a push.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch: in-order imem requests, prefetch queue, redirect flush with stale-response drop.
// Define FETCH_PERF_EN to add saturating counters perf_fetched, perf_flushed and perf_empty.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       INSTR_W    = 32,
    parameter int unsigned       QDEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEFAULT_EXC_VECTOR)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ex_if_stall,
    input  logic               id_if_selpcsource,
    input  logic [1:0]         id_if_selpctype,
    input  logic [ADDR_W-1:0]  id_if_rega,
    input  logic [ADDR_W-1:0]  id_if_pcimd2ext,
    input  logic [ADDR_W-1:0]  id_if_pcindex,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instruc,
    output logic [ADDR_W-1:0]  if_id_nextpc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed,
    output logic [31:0]        perf_empty
`endif
);

    localparam int unsigned   CntW    = $clog2(QDEPTH + 1);
    localparam logic [CntW:0] QDepthW = (CntW + 1)'(QDEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0]  nextpc;
        logic [INSTR_W-1:0] instruc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_q, resp_pc_q, target;
    logic [CntW-1:0]   outstanding_q, drop_q, q_count, drop_new;
    logic [CntW:0]     inflight;
    logic              req_en_q, redirect, issue, rsp_ok, rsp_live, bypass;
    logic              q_push, q_pop, q_full, q_empty;
    entry_t            q_head, rsp_entry;

    assign redirect = id_if_selpcsource && !ex_if_stall;

    always_comb begin
        target = EXC_VECTOR;
        case (id_if_selpctype)
            SEL_BRANCH: target = id_if_pcimd2ext;
            SEL_REG:    target = id_if_rega;
            SEL_INDEX:  target = id_if_pcindex;
            SEL_EXC:    target = EXC_VECTOR;
        endcase
    end

    // Live slots: queued words plus responses still due that will not be dropped.
    assign inflight  = {1'b0, q_count} + {1'b0, outstanding_q} - {1'b0, drop_q};
    assign issue     = req_en_q && !redirect && (inflight < QDepthW);
    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;

    assign rsp_ok            = imem_rvalid && (outstanding_q != '0);
    assign rsp_live          = rsp_ok && (drop_q == '0) && !redirect;
    assign rsp_entry.nextpc  = resp_pc_q + ADDR_W'(4);
    assign rsp_entry.instruc = imem_rdata;
    assign drop_new          = outstanding_q - CntW'(rsp_ok);

    // An empty queue forwards the arriving word straight into the output register.
    assign bypass = rsp_live && q_empty && !ex_if_stall;
    assign q_push = rsp_live && !bypass;
    assign q_pop  = !ex_if_stall && !redirect && !q_empty;

    fetch_fifo #(
        .DEPTH   (QDEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (redirect),
        .push  (q_push),
        .wdata (rsp_entry),
        .pop   (q_pop),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_en_q      <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            req_en_q <= 1'b1;
            if (redirect) begin
                fetch_pc_q    <= target;
                resp_pc_q     <= target;
                outstanding_q <= drop_new;
                drop_q        <= drop_new;
            end else begin
                if (issue)    fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
                if (rsp_live) resp_pc_q  <= resp_pc_q + ADDR_W'(4);
                outstanding_q <= outstanding_q + CntW'(issue) - CntW'(rsp_ok);
                if (rsp_ok && (drop_q != '0)) drop_q <= drop_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_id_valid   <= 1'b0;
            if_id_instruc <= '0;
            if_id_nextpc  <= RESET_PC;
        end else if (!ex_if_stall) begin
            if (redirect) begin
                if_id_valid   <= 1'b0;
                if_id_instruc <= '0;
                if_id_nextpc  <= target;
            end else if (!q_empty) begin
                if_id_valid   <= 1'b1;
                if_id_instruc <= q_head.instruc;
                if_id_nextpc  <= q_head.nextpc;
            end else if (bypass) begin
                if_id_valid   <= 1'b1;
                if_id_instruc <= rsp_entry.instruc;
                if_id_nextpc  <= rsp_entry.nextpc;
            end else begin
                if_id_valid   <= 1'b0;
                if_id_instruc <= '0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, flushed_q, empty_q;
    logic [32:0] flush_sum;

    assign flush_sum = {1'b0, flushed_q} + 33'(q_count) + 33'(drop_new);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetched_q <= '0;
            flushed_q <= '0;
            empty_q   <= '0;
        end else begin
            if (rsp_live && (fetched_q != '1)) fetched_q <= fetched_q + 32'd1;
            if (redirect) flushed_q <= flush_sum[32] ? '1 : flush_sum[31:0];
            if (!ex_if_stall && q_empty && (empty_q != '1)) empty_q <= empty_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
    assign perf_empty   = empty_q;
`endif

    rsp_without_req_a: assert property (@(posedge clock) disable iff (!reset)
        imem_rvalid |-> (outstanding_q != '0));

    fifo_overflow_a: assert property (@(posedge clock) disable iff (!reset)
        q_push |-> (!q_full || q_pop));

endmodule
